// File: rtl/ring_monitor.sv
// Receive-side checker for a one-hot shift-right ring counter bus: validates one-hot, decodes phase, tracks lock.
// Latency: 1 cycle; every output is registered and reflects the sample captured on the previous edge.
// Backpressure: none; samples are qualified by in_valid and invalid cycles are transparent (pulses drop to 0).
//
// Ports:
//   in_clk, in_clr_n      clock (rising edge) and asynchronous active-low reset
//   in_valid, in_q        ring sample strobe and WIDTH-bit ring vector
//   in_err_clr            synchronous clear of o_err_cnt (wins over a same-cycle increment)
//   o_idx, o_onehot_ok    decoded phase of the last one-hot sample, one-hot status of the last sample
//   o_locked              FSM is in LOCK or SLIP
//   o_err, o_err_cnt      one-cycle sequence error pulse, saturating error count
//   o_wrap                one-cycle pulse per completed lap (good sample at index WIDTH-1 while locked)
module ring_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8,
  localparam int IW      = $clog2(WIDTH)
) (
  input  logic             in_clk,
  input  logic             in_clr_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_q,
  input  logic             in_err_clr,
  output logic [IW-1:0]    o_idx,
  output logic             o_onehot_ok,
  output logic             o_locked,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic             o_wrap
);

  // Counter widths sized to hold the terminal values themselves.
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {HUNT, ACQ, LOCK, SLIP} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     good_cnt_q, good_cnt_d;
  logic [BW-1:0]     bad_cnt_q, bad_cnt_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              wrap_q, wrap_d;

  logic              oh;
  logic              good;
  logic              at_top;
  logic [IW-1:0]     idx_enc;
  logic [WIDTH-1:0]  rot_prev;
  logic [GW-1:0]     good_inc;
  logic [BW-1:0]     bad_inc;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign oh       = (in_q != '0) && ((in_q & (in_q - ONE)) == '0);
  // Shift-right ring: bit 0 wraps round to the MSB.
  assign rot_prev = {prev_q[0], prev_q[WIDTH-1:1]};
  assign good     = oh && have_prev_q && (in_q == rot_prev);
  assign at_top   = (idx_enc == IW'(WIDTH - 1));
  assign good_inc = good_cnt_q + GW'(1);
  assign bad_inc  = bad_cnt_q + BW'(1);

  // Priority encoder; its value only matters when the sample is one-hot.
  always_comb begin
    idx_enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_q[i]) idx_enc = IW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    idx_d       = idx_q;
    ok_d        = ok_q;
    err_d       = 1'b0;
    wrap_d      = 1'b0;

    if (in_valid) begin
      // History advances on every sample, legal or not, so the next check
      // compares against what was actually seen.
      prev_d      = in_q;
      have_prev_d = 1'b1;
      ok_d        = oh;
      if (oh) idx_d = idx_enc;

      case (state_q)
        HUNT: begin
          if (oh) begin
            state_d    = ACQ;
            good_cnt_d = '0;
          end
        end
        ACQ: begin
          if (good) begin
            good_cnt_d = good_inc;
            if (good_inc == GW'(LOCK_CNT)) begin
              state_d   = LOCK;
              bad_cnt_d = '0;
              wrap_d    = at_top;
            end
          end else if (oh) begin
            // A legal but out-of-sequence sample restarts acquisition from here.
            good_cnt_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCK: begin
          if (good) begin
            wrap_d = at_top;
          end else begin
            err_d     = 1'b1;
            bad_cnt_d = BW'(1);
            state_d   = (LOSS_CNT == 1) ? HUNT : SLIP;
          end
        end
        SLIP: begin
          if (good) begin
            state_d   = LOCK;
            bad_cnt_d = '0;
            wrap_d    = at_top;
          end else begin
            err_d     = 1'b1;
            bad_cnt_d = bad_inc;
            if (bad_inc == BW'(LOSS_CNT)) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Clear takes priority over a coincident increment; the count saturates.
    err_cnt_d = err_cnt_q;
    if (in_err_clr) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge in_clk or negedge in_clr_n) begin
    if (!in_clr_n) begin
      state_q     <= HUNT;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      idx_q       <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      idx_q       <= idx_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      wrap_q      <= wrap_d;
    end
  end

  assign o_idx       = idx_q;
  assign o_onehot_ok = ok_q;
  assign o_locked    = (state_q == LOCK) || (state_q == SLIP);
  assign o_err       = err_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_wrap      = wrap_q;

endmodule

// File: tb/tb_ring_monitor.sv
// Bench for ring_monitor: three instances (defaults, LOSS_CNT=3, ERR_W=2/LOSS_CNT=8) share one stimulus.
// Directed samples push hand-computed expectations; a negedge monitor pops and compares per captured sample.
// Idle cycles are checked for pulse outputs returning to 0.
module tb_ring_monitor;

  logic       in_clk = 1'b0;
  logic       in_clr_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_q = 4'b0000;
  logic       in_err_clr = 1'b0;

  logic [1:0] idx0, idx1, idx2;
  logic       ok0, ok1, ok2, lk0, lk1, lk2, err0, err1, err2, wrap0, wrap1, wrap2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  always #5 in_clk = ~in_clk;

  ring_monitor u0 (
    .in_clk(in_clk), .in_clr_n(in_clr_n), .in_valid(in_valid), .in_q(in_q), .in_err_clr(in_err_clr),
    .o_idx(idx0), .o_onehot_ok(ok0), .o_locked(lk0), .o_err(err0), .o_err_cnt(cnt0), .o_wrap(wrap0));

  ring_monitor #(.LOSS_CNT(3)) u1 (
    .in_clk(in_clk), .in_clr_n(in_clr_n), .in_valid(in_valid), .in_q(in_q), .in_err_clr(in_err_clr),
    .o_idx(idx1), .o_onehot_ok(ok1), .o_locked(lk1), .o_err(err1), .o_err_cnt(cnt1), .o_wrap(wrap1));

  ring_monitor #(.ERR_W(2), .LOSS_CNT(8)) u2 (
    .in_clk(in_clk), .in_clr_n(in_clr_n), .in_valid(in_valid), .in_q(in_q), .in_err_clr(in_err_clr),
    .o_idx(idx2), .o_onehot_ok(ok2), .o_locked(lk2), .o_err(err2), .o_err_cnt(cnt2), .o_wrap(wrap2));

  // Packed observation: [13:12] idx, 11 ok, 10 locked, 9 err, [8:1] err_cnt, 0 wrap
  typedef struct {
    int          sel;
    logic [13:0] exp;
    string       name;
  } exp_t;

  exp_t  exp_q[$];
  int    nvec = 0;
  int    nerr = 0;
  int    cur_sel = 0;
  int    seq = 0;
  string tag = "init";
  logic  cap_vld = 1'b0;

  function automatic logic [13:0] act_of(int s);
    case (s)
      0:       return {idx0, ok0, lk0, err0, cnt0, wrap0};
      1:       return {idx1, ok1, lk1, err1, cnt1, wrap1};
      default: return {idx2, ok2, lk2, err2, 6'b0, cnt2, wrap2};
    endcase
  endfunction

  function automatic string fmt(logic [13:0] v);
    return $sformatf("idx=%0d ok=%0b lk=%0b err=%0b cnt=%0d wrap=%0b",
                     v[13:12], v[11], v[10], v[9], v[8:1], v[0]);
  endfunction

  // Tracks whether the last rising edge captured a sample (the DUT's output-valid moment).
  always @(posedge in_clk) cap_vld <= in_valid;

  // Monitor: compares after every captured sample; on idle cycles checks pulses are low.
  always @(negedge in_clk) begin
    if (in_clr_n) begin
      if (cap_vld) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_output: got %s, required no output", fmt(act_of(cur_sel)));
        end else begin
          exp_t e;
          logic [13:0] a;
          e = exp_q.pop_front();
          a = act_of(e.sel);
          if (a !== e.exp) begin
            nerr++;
            $display("FAIL %s u%0d: got %s, required %s", e.name, e.sel, fmt(a), fmt(e.exp));
          end
        end
      end else begin
        logic [13:0] a;
        a = act_of(cur_sel);
        nvec++;
        if (a[9] !== 1'b0 || a[0] !== 1'b0) begin
          nerr++;
          $display("FAIL %s_idle_pulse u%0d: got err=%0b wrap=%0b, required 0 0", tag, cur_sel, a[9], a[0]);
        end
      end
    end
  end

  task automatic smp(input logic [3:0] q, input logic clr, input logic [1:0] idx, input logic ok,
                     input logic lk, input logic err, input int cnt, input logic wrap);
    exp_t e;
    @(posedge in_clk);
    #1;
    in_valid   = 1'b1;
    in_q       = q;
    in_err_clr = clr;
    e.sel  = cur_sel;
    e.exp  = {idx, ok, lk, err, 8'(cnt), wrap};
    e.name = $sformatf("%s_%0d", tag, seq);
    seq++;
    exp_q.push_back(e);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge in_clk);
      #1;
      in_valid   = 1'b0;
      in_err_clr = 1'b0;
    end
  endtask

  task automatic check_zero(input string nm);
    for (int s = 0; s < 3; s++) begin
      logic [13:0] a;
      a = act_of(s);
      nvec++;
      if (a !== 14'd0) begin
        nerr++;
        $display("FAIL %s u%0d: got %s, required all zero", nm, s, fmt(a));
      end
    end
  endtask

  // Asserts reset away from the clock edge (mid-cycle), checks outputs clear at once, then releases.
  task automatic do_reset(input string nm);
    gap(1);
    @(negedge in_clk);
    #2;
    in_clr_n = 1'b0;
    #1;
    check_zero(nm);
    repeat (2) @(negedge in_clk);
    #2;
    in_clr_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    in_clr_n = 1'b0;
    #1;
    check_zero("reset_initial");
    #10;
    in_clr_n = 1'b1;

    // Clean lock on the default instance.
    cur_sel = 0; tag = "clean";
    smp(4'b1000, 0, 3, 1, 0, 0, 0, 0);
    smp(4'b0100, 0, 2, 1, 0, 0, 0, 0);
    smp(4'b0010, 0, 1, 1, 1, 0, 0, 0);
    smp(4'b0001, 0, 0, 1, 1, 0, 0, 0);
    smp(4'b1000, 0, 3, 1, 1, 0, 0, 1);
    smp(4'b0100, 0, 2, 1, 1, 0, 0, 0);
    smp(4'b0010, 0, 1, 1, 1, 0, 0, 0);
    smp(4'b0001, 0, 0, 1, 1, 0, 0, 0);
    smp(4'b1000, 0, 3, 1, 1, 0, 0, 1);

    // Glitch in lock with LOSS_CNT=2: two errors, drop to HUNT, relock.
    tag = "glitch2";
    smp(4'b0100, 0, 2, 1, 1, 0, 0, 0);
    smp(4'b0110, 0, 2, 0, 1, 1, 1, 0);
    smp(4'b0010, 0, 1, 1, 0, 1, 2, 0);
    smp(4'b0001, 0, 0, 1, 0, 0, 2, 0);
    smp(4'b1000, 0, 3, 1, 0, 0, 2, 0);
    smp(4'b0100, 0, 2, 1, 1, 0, 2, 0);
    smp(4'b0010, 0, 1, 1, 1, 0, 2, 0);
    smp(4'b0001, 0, 0, 1, 1, 0, 2, 0);
    smp(4'b1000, 0, 3, 1, 1, 0, 2, 1);

    // Stalls: gaps are transparent to the sequence check.
    tag = "stall";
    gap(3);
    smp(4'b0100, 0, 2, 1, 1, 0, 2, 0);
    gap(10);
    smp(4'b0010, 0, 1, 1, 1, 0, 2, 0);
    smp(4'b0001, 0, 0, 1, 1, 0, 2, 0);
    gap(1);
    smp(4'b1000, 0, 3, 1, 1, 0, 2, 1);
    gap(2);

    // Error count clear on a clean sample.
    tag = "clr";
    smp(4'b0100, 1, 2, 1, 1, 0, 0, 0);
    smp(4'b0010, 0, 1, 1, 1, 0, 0, 0);

    // Reset mid-lap while locked, then restart hunting.
    do_reset("reset_midstream");
    tag = "after_rst";
    smp(4'b1000, 0, 3, 1, 0, 0, 0, 0);
    smp(4'b0100, 0, 2, 1, 0, 0, 0, 0);
    smp(4'b0010, 0, 1, 1, 1, 0, 0, 0);

    // Illegal streams never lock and never count; then ACQ drop and reseed.
    do_reset("reset_illegal");
    tag = "illegal";
    smp(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    smp(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    smp(4'b1100, 0, 0, 0, 0, 0, 0, 0);
    smp(4'b1100, 0, 0, 0, 0, 0, 0, 0);
    smp(4'b1100, 0, 0, 0, 0, 0, 0, 0);
    tag = "acq";
    smp(4'b0010, 0, 1, 1, 0, 0, 0, 0);
    smp(4'b0000, 0, 1, 0, 0, 0, 0, 0);
    smp(4'b0010, 0, 1, 1, 0, 0, 0, 0);
    smp(4'b0100, 0, 2, 1, 0, 0, 0, 0);
    smp(4'b0010, 0, 1, 1, 0, 0, 0, 0);
    smp(4'b0001, 0, 0, 1, 1, 0, 0, 0);
    smp(4'b1000, 0, 3, 1, 1, 0, 0, 1);

    // Lock entry on the top index pulses wrap.
    do_reset("reset_entry");
    tag = "entry_wrap";
    smp(4'b0010, 0, 1, 1, 0, 0, 0, 0);
    smp(4'b0001, 0, 0, 1, 0, 0, 0, 0);
    smp(4'b1000, 0, 3, 1, 1, 0, 0, 1);

    // Same glitch with LOSS_CNT=3: rides through SLIP and stays locked.
    do_reset("reset_loss3");
    cur_sel = 1; tag = "glitch3";
    smp(4'b1000, 0, 3, 1, 0, 0, 0, 0);
    smp(4'b0100, 0, 2, 1, 0, 0, 0, 0);
    smp(4'b0010, 0, 1, 1, 1, 0, 0, 0);
    smp(4'b0001, 0, 0, 1, 1, 0, 0, 0);
    smp(4'b1000, 0, 3, 1, 1, 0, 0, 1);
    smp(4'b0100, 0, 2, 1, 1, 0, 0, 0);
    smp(4'b0110, 0, 2, 0, 1, 1, 1, 0);
    smp(4'b0010, 0, 1, 1, 1, 1, 2, 0);
    smp(4'b0001, 0, 0, 1, 1, 0, 2, 0);
    smp(4'b1000, 0, 3, 1, 1, 0, 2, 1);

    // Saturation at ERR_W=2 and clear coincident with an error.
    do_reset("reset_sat");
    cur_sel = 2; tag = "sat";
    smp(4'b1000, 0, 3, 1, 0, 0, 0, 0);
    smp(4'b0100, 0, 2, 1, 0, 0, 0, 0);
    smp(4'b0010, 0, 1, 1, 1, 0, 0, 0);
    smp(4'b0001, 0, 0, 1, 1, 0, 0, 0);
    smp(4'b0001, 0, 0, 1, 1, 1, 1, 0);
    smp(4'b0001, 0, 0, 1, 1, 1, 2, 0);
    smp(4'b0001, 0, 0, 1, 1, 1, 3, 0);
    smp(4'b0001, 0, 0, 1, 1, 1, 3, 0);
    smp(4'b0001, 0, 0, 1, 1, 1, 3, 0);
    smp(4'b0001, 1, 0, 1, 1, 1, 0, 0);
    smp(4'b1000, 0, 3, 1, 1, 0, 0, 1);

    gap(3);
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
